// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the CPU and the host loader.
// Each access runs IDLE -> ISSUE -> CAPTURE -> ACK; a starvation counter bounds host wait.
module data_memory_arbiter #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned HOST_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_host
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(HOST_STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              lat_we, lat_we_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt, host_rdata_nxt;
  logic              cpu_ack_nxt, host_ack_nxt;
  logic              busy_nxt, grant_nxt;
  logic              host_win;

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      busy       <= 1'b0;
      grant_host <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_we     <= lat_we_nxt;
      starve_cnt <= starve_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      host_rdata <= host_rdata_nxt;
      cpu_ack    <= cpu_ack_nxt;
      host_ack   <= host_ack_nxt;
      busy       <= busy_nxt;
      grant_host <= grant_nxt;
    end
  end

  // Next-state, arbitration and output computation.
  always_comb begin
    state_nxt      = state;
    lat_we_nxt     = lat_we;
    starve_nxt     = starve_cnt;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    cpu_rdata_nxt  = cpu_rdata;
    host_rdata_nxt = host_rdata;
    cpu_ack_nxt    = 1'b0;
    host_ack_nxt   = 1'b0;
    busy_nxt       = 1'b0;
    grant_nxt      = grant_host;
    host_win       = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_req || host_req) begin
          host_win   = host_req && (!cpu_req || (starve_cnt == STARVE_LIMIT));
          grant_nxt  = host_win;
          lat_we_nxt = host_win ? host_we    : cpu_we;
          addr_nxt   = host_win ? host_addr  : cpu_addr;
          wdata_nxt  = host_win ? host_wdata : cpu_wdata;
          // Count CPU wins only while the host is actually waiting.
          if (host_win || !host_req) begin
            starve_nxt = '0;
          end else if (starve_cnt < STARVE_LIMIT) begin
            starve_nxt = starve_cnt + CNT_W'(1);
          end
          busy_nxt  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy_nxt  = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!lat_we) begin
          if (grant_host) host_rdata_nxt = mem_rdata;
          else            cpu_rdata_nxt  = mem_rdata;
        end
        cpu_ack_nxt  = !grant_host;
        host_ack_nxt = grant_host;
        busy_nxt     = 1'b1;
        state_nxt    = ACK;
      end
      ACK: begin
        grant_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are gated by reset so a reset during ISSUE commits nothing.
  assign mem_we    = (state == ISSUE) &&  lat_we && !reset;
  assign mem_re    = (state == ISSUE) && !lat_we && !reset;
  assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: vector table plus hand-written corner sequences.
module tb_data_memory_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_ack;
  logic [9:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_we, mem_re, busy, grant_host;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [1024];
  logic [7:0] cpu_rd_m, host_rd_m;

  typedef struct {
    logic       host;
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];
  logic exp_order [6];
  logic got_order [6];

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .grant_host(grant_host)
  );

  // Synchronous 1024x8 memory macro, read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One isolated transaction from IDLE, checked cycle by cycle through ACK.
  task automatic run_txn(input vec_t v);
    @(negedge clk);
    if (v.host) begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chkb("txn_we", mem_we, v.we);
        chkb("txn_re", mem_re, !v.we);
        chkw("txn_addr", 16'(mem_addr), 16'(v.addr));
        if (v.we) chkw("txn_wdata", 16'(mem_wdata), 16'(v.wdata));
        chkb("txn_grant", grant_host, v.host);
        chkb("txn_busy", busy, 1'b1);
      end else if (k == 2) begin
        chkb("txn_strobe_off", mem_we | mem_re, 1'b0);
        chkb("txn_early_ack", cpu_ack | host_ack, 1'b0);
      end else if (k == 3) begin
        chkb("txn_cpu_ack", cpu_ack, !v.host);
        chkb("txn_host_ack", host_ack, v.host);
        if (v.host) begin
          if (!v.we) host_rd_m = v.exp_rdata;
          chkw("txn_host_rdata", 16'(host_rdata), 16'(host_rd_m));
          host_req = 1'b0;
        end else begin
          if (!v.we) cpu_rd_m = v.exp_rdata;
          chkw("txn_cpu_rdata", 16'(cpu_rdata), 16'(cpu_rd_m));
          chkb("txn_stall", cpu_stall, 1'b0);
          cpu_req = 1'b0;
        end
      end else begin
        chkb("txn_idle_busy", busy, 1'b0);
        chkb("txn_ack_pulse", cpu_ack | host_ack, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    cpu_rd_m  = 8'h00;
    host_rd_m = 8'h00;
    vecs[0] = '{host: 1'b0, we: 1'b1, addr: 10'h3F0, wdata: 8'hA5, exp_rdata: 8'h00};
    vecs[1] = '{host: 1'b0, we: 1'b0, addr: 10'h3F0, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[2] = '{host: 1'b1, we: 1'b1, addr: 10'h000, wdata: 8'h11, exp_rdata: 8'h00};
    vecs[3] = '{host: 1'b1, we: 1'b1, addr: 10'h3FF, wdata: 8'h22, exp_rdata: 8'h00};
    vecs[4] = '{host: 1'b1, we: 1'b0, addr: 10'h3F0, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[5] = '{host: 1'b0, we: 1'b0, addr: 10'h000, wdata: 8'h00, exp_rdata: 8'h11};
    vecs[6] = '{host: 1'b0, we: 1'b1, addr: 10'h200, wdata: 8'h77, exp_rdata: 8'h00};
    vecs[7] = '{host: 1'b1, we: 1'b0, addr: 10'h3FF, wdata: 8'h00, exp_rdata: 8'h22};
    vecs[8] = '{host: 1'b1, we: 1'b0, addr: 10'h011, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[9] = '{host: 1'b0, we: 1'b0, addr: 10'h3FF, wdata: 8'h00, exp_rdata: 8'h22};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held with both requests up: CPU read 0x010, host write 0x011 = 0x5A.
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010; cpu_wdata = 8'h00;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h011; host_wdata = 8'h5A;
    repeat (2) begin
      @(negedge clk);
      chkw("rst_ctrl", 16'({cpu_ack, host_ack, busy, grant_host, mem_we, mem_re}), 16'h0);
      chkw("rst_rdata", {cpu_rdata, host_rdata}, 16'h0);
      chkw("rst_mem_addr", 16'(mem_addr), 16'h0);
      chkw("rst_mem_wdata", 16'(mem_wdata), 16'h0);
    end
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chkb("sim_re", mem_re, c == 1);
      chkb("sim_we", mem_we, c == 5);
      chkb("sim_cpu_ack", cpu_ack, c == 3);
      chkb("sim_host_ack", host_ack, c == 7);
      if (c == 1) begin
        chkw("sim_cpu_addr", 16'(mem_addr), 16'h010);
        chkb("sim_cpu_grant", grant_host, 1'b0);
        chkb("sim_stall", cpu_stall, 1'b1);
      end
      if (c == 3) begin
        chkw("sim_cpu_rdata", 16'(cpu_rdata), 16'h00);
        chkb("sim_stall_ack", cpu_stall, 1'b0);
        cpu_req = 1'b0;
      end
      if (c == 7) begin
        chkb("sim_host_grant", grant_host, 1'b1);
        chkw("sim_host_addr", 16'(mem_addr), 16'h011);
        chkw("sim_host_wdata", 16'(mem_wdata), 16'h5A);
        host_req = 1'b0;
      end
    end

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Starvation: both requests held, host must get the fifth grant.
    begin
      int n = 0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h001;
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'h002;
      for (int c = 0; c < 60 && n < 6; c++) begin
        @(negedge clk);
        if (cpu_ack || host_ack) begin
          got_order[n] = host_ack;
          n++;
        end
      end
      cpu_req = 1'b0;
      host_req = 1'b0;
      chkw("starve_grants", 16'(n), 16'd6);
      for (int i = 0; i < 6; i++)
        if (i < n) chkb("starve_order", got_order[i], exp_order[i]);
    end

    // Reset during ISSUE of a host write 0xFF to 0x200.
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h200; host_wdata = 8'hFF;
    @(negedge clk);
    chkb("rstiss_pre_we", mem_we, 1'b1);
    reset = 1'b1;
    host_req = 1'b0;
    #1;
    chkb("rstiss_we", mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cpu_rd_m = 8'h00;
    host_rd_m = 8'h00;
    chkw("rstiss_state", 16'({busy, grant_host, cpu_ack, host_ack}), 16'h0);
    chkw("rstiss_rdata", {cpu_rdata, host_rdata}, 16'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chkb("rstiss_no_ack", host_ack, 1'b0);
    end
    run_txn('{host: 1'b0, we: 1'b0, addr: 10'h200, wdata: 8'h00, exp_rdata: 8'h77});

    // Back-to-back host reads with req held: 0x000 then 0x3FF.
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chkb("b2b_ack", host_ack, (c == 3) || (c == 7));
      chkw("b2b_rdata", 16'(host_rdata), (c < 3) ? 16'h00 : ((c < 7) ? 16'h11 : 16'h22));
      if (c == 3) host_addr = 10'h3FF;
      if (c == 7) host_req = 1'b0;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
